// File: rtl/bus_hold_pkg.sv
// Shared types and constants for the bus snapshot-and-hold controller.
package bus_hold_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } hold_state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_CNT_W  = 4;
    localparam int SNAP_CNT_W = 8;

endpackage

// File: rtl/hold_down_counter.sv
// Loadable down-counter that tracks the remaining cycles of a hold.
module hold_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/bus_hold_ctrl.sv
// Snapshot-and-hold controller driving the 2:1 bus selector.
// Optional build macro PENDING_REQ_EN queues one request arriving outside IDLE.
module bus_hold_ctrl
    import bus_hold_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      live_data,
    input  logic                  freeze_req,
    input  logic [CNT_W-1:0]      hold_len,
    input  logic                  abort,
    output logic [WIDTH-1:0]      shadow_data,
    output logic                  sel,
    output logic                  busy,
    output logic                  done,
    output logic [SNAP_CNT_W-1:0] snap_cnt
);

    hold_state_t           state_q, state_d;
    logic [WIDTH-1:0]      shadow_q, shadow_d;
    logic [SNAP_CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic                  sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start;
    logic                  cnt_dec;
    logic                  cnt_is_one;
    logic [CNT_W-1:0]      req_len;
    logic [CNT_W-1:0]      load_len;
    logic                  pend_active;

`ifdef PENDING_REQ_EN
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pend_len_q, pend_len_d;

    assign pend_active = pend_q;
    // A live request in IDLE carries the newest length; otherwise replay the stored one.
    assign req_len     = freeze_req ? hold_len : pend_len_q;

    always_comb begin
        pend_d     = pend_q;
        pend_len_d = pend_len_q;
        if (start) begin
            pend_d = 1'b0;
        end else if (freeze_req && (state_q != ST_IDLE)) begin
            pend_d     = 1'b1;
            pend_len_d = hold_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_len_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_len_q <= pend_len_d;
        end
    end
`else
    assign pend_active = 1'b0;
    assign req_len     = hold_len;
`endif

    assign start    = (state_q == ST_IDLE) && (freeze_req || pend_active) && !abort;
    assign load_len = (req_len == '0) ? CNT_W'(1) : req_len;
    assign cnt_dec  = (state_q == ST_HOLD);

    hold_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (load_len),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        snap_cnt_d = snap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HOLD;
                    shadow_d   = live_data;
                    snap_cnt_d = snap_cnt_q + SNAP_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (abort || cnt_is_one) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        sel_d  = (state_d == ST_HOLD);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            snap_cnt_q <= '0;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            snap_cnt_q <= snap_cnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign shadow_data = shadow_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign snap_cnt    = snap_cnt_q;

endmodule

// File: tb/tb_bus_hold_ctrl.sv
// Randomized self-checking bench for bus_hold_ctrl using a cycle-timeline reference model.
module tb_bus_hold_ctrl;

`ifdef PENDING_REQ_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] live_data;
    logic       freeze_req;
    logic [3:0] hold_len;
    logic       abort;
    logic [7:0] shadow_data;
    logic       sel;
    logic       busy;
    logic       done;
    logic [7:0] snap_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: absolute cycle numbers of the current hold's milestones.
    int         cyc;
    int         acc_t;
    int         sel_end;
    int         done_at;
    int         free_at;
    bit         m_pend;
    logic [3:0] m_plen;
    logic [7:0] m_shadow;
    logic [7:0] m_cnt;

    bus_hold_ctrl #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .live_data   (live_data),
        .freeze_req  (freeze_req),
        .hold_len    (hold_len),
        .abort       (abort),
        .shadow_data (shadow_data),
        .sel         (sel),
        .busy        (busy),
        .done        (done),
        .snap_cnt    (snap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_init();
        cyc      = 0;
        acc_t    = -10;
        sel_end  = -1;
        done_at  = -1;
        free_at  = 0;
        m_pend   = 1'b0;
        m_plen   = '0;
        m_shadow = '0;
        m_cnt    = '0;
    endtask

    task automatic check_outputs();
        chk("sel",      {31'd0, sel},  {31'd0, (cyc > acc_t) && (cyc <= sel_end)});
        chk("busy",     {31'd0, busy}, {31'd0, (cyc > acc_t) && (cyc < free_at)});
        chk("done",     {31'd0, done}, {31'd0, cyc == done_at});
        chk("shadow",   {24'd0, shadow_data}, {24'd0, m_shadow});
        chk("snap_cnt", {24'd0, snap_cnt},    {24'd0, m_cnt});
    endtask

    // One clock: model consumes the inputs present at the edge, then outputs are compared.
    task automatic step();
        bit         idle;
        bit         in_hold;
        logic [3:0] len;
        int         n;
        @(posedge clk);
        idle    = (cyc >= free_at);
        in_hold = (cyc > acc_t) && (cyc <= sel_end);
        if (idle) begin
            if ((freeze_req || m_pend) && !abort) begin
                len      = freeze_req ? hold_len : m_plen;
                n        = (len == 4'd0) ? 1 : int'(len);
                m_shadow = live_data;
                m_cnt    = m_cnt + 8'd1;
                acc_t    = cyc;
                sel_end  = cyc + n;
                done_at  = cyc + n + 1;
                free_at  = cyc + n + 2;
                m_pend   = 1'b0;
            end
        end else begin
            if (freeze_req && PEND_EN) begin
                m_pend = 1'b1;
                m_plen = hold_len;
            end
            if (in_hold && abort) begin
                sel_end = cyc;
                done_at = cyc + 1;
                free_at = cyc + 2;
            end
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit f, input bit a, input logic [3:0] len);
        freeze_req = f;
        abort      = a;
        hold_len   = len;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_sel",    {31'd0, sel},  32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_shadow", {24'd0, shadow_data}, 32'd0);
        chk("rst_cnt",    {24'd0, snap_cnt},    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    logic [7:0] cnt_before;

    initial begin
        live_data  = 8'h00;
        drive(1'b0, 1'b0, 4'd0);
        do_reset();

        // Basic hold of 3 with live bus changing mid-hold
        live_data = 8'hA5;
        drive(1'b1, 1'b0, 4'd3);
        step();
        drive(1'b0, 1'b0, 4'd0);
        live_data = 8'h3C;
        for (int i = 0; i < 5; i++) step();
        chk("basic_shadow", {24'd0, shadow_data}, 32'h0000_00A5);
        chk("basic_cnt",    {24'd0, snap_cnt},    32'd1);

        // Zero length behaves as one
        drive(1'b1, 1'b0, 4'd0);
        step();
        drive(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step();

        // Abort in the 2nd hold cycle of a 10-cycle hold
        live_data = 8'h5A;
        drive(1'b1, 1'b0, 4'd10);
        step();
        drive(1'b0, 1'b0, 4'd0);
        step();
        drive(1'b0, 1'b1, 4'd0);
        step();
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_sel",  {31'd0, sel},  32'd0);
        drive(1'b0, 1'b0, 4'd0);
        step();
        step();

        // Request and abort together in IDLE are dropped
        cnt_before = snap_cnt;
        live_data  = 8'hEE;
        drive(1'b1, 1'b1, 4'd5);
        step();
        drive(1'b0, 1'b0, 4'd0);
        step();
        chk("req_abort_cnt", {24'd0, snap_cnt}, {24'd0, cnt_before});

        // Request arriving in the 2nd hold cycle
        cnt_before = snap_cnt;
        drive(1'b1, 1'b0, 4'd3);
        step();
        drive(1'b0, 1'b0, 4'd0);
        step();
        drive(1'b1, 1'b0, 4'd2);
        step();
        drive(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) step();
        chk("req_in_hold_cnt", {24'd0, snap_cnt},
            {24'd0, cnt_before + (PEND_EN ? 8'd2 : 8'd1)});

        // 256 holds wrap the snapshot counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            live_data = 8'($urandom);
            drive(1'b1, 1'b0, 4'd0);
            step();
            drive(1'b0, 1'b0, 4'd0);
            step();
            step();
        end
        chk("wrap_cnt", {24'd0, snap_cnt}, 32'd0);

        // Reset pulsed mid-hold clears outputs at once and suppresses done
        live_data = 8'h77;
        drive(1'b1, 1'b0, 4'd8);
        step();
        drive(1'b0, 1'b0, 4'd0);
        step();
        step();
        do_reset();
        for (int i = 0; i < 12; i++) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            live_data  = 8'($urandom);
            freeze_req = ($urandom_range(0, 2) == 0);
            abort      = ($urandom_range(0, 9) == 0);
            hold_len   = 4'($urandom);
            step();
        end
        drive(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 40; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_hold_ctrl.md
# bus_hold_ctrl

Snapshot-and-hold controller that sits directly upstream of the 8-lane 2:1 bus selector. It captures the live bus into a shadow register on request and drives the selector's select line high for a programmed number of cycles. While select is high, the selector forwards the frozen shadow copy; otherwise it forwards the live bus. The block also counts completed snapshots for software visibility.

## Interface
Parameters:
- WIDTH, 8, lane count of live and shadow buses (matches selector width)
- CNT_W, 4, width of hold-length input and internal down-counter

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- live_data  in  WIDTH  live bus; also the selector's "select low" inputs
- freeze_req  in  1  single-cycle request to snapshot and hold
- hold_len  in  CNT_W  hold duration in cycles, sampled on accept; 0 is treated as 1
- abort  in  1  terminate an active hold
- shadow_data  out  WIDTH  frozen copy; drives the selector's "select high" inputs
- sel  out  1  selector control; 1 = forward shadow_data
- busy  out  1  high in HOLD and GAP
- done  out  1  one-cycle pulse in the GAP cycle after a hold ends (normal or aborted)
- snap_cnt  out  8  count of accepted freeze requests, wraps 255 -> 0

## Operation
- Reset values: sel=0, busy=0, done=0, shadow_data=0, snap_cnt=0, state=IDLE, counter=0.
- States: IDLE, HOLD, GAP.
- IDLE:
  - freeze_req=1 and abort=0: shadow_data <= live_data, counter <= max(hold_len,1), snap_cnt++, go to HOLD.
  - freeze_req=1 and abort=1 in the same cycle: abort wins; request dropped, no capture, no count.
- HOLD:
  - sel=1 and busy=1.
  - Counter decrements each cycle. Leave HOLD toward GAP on the edge where the counter is 1.
  - abort=1: go to GAP at the next edge regardless of the counter.
  - shadow_data is stable for the whole hold.
- GAP: sel=0, busy=1, done=1 for exactly one cycle, then IDLE.
- freeze_req outside IDLE: dropped, unless PENDING_REQ_EN (see Configuration).
- shadow_data holds its last value after release until the next capture.
- snap_cnt is 8-bit and wraps; no saturation.

## Timing
- freeze_req accepted in cycle t gives:
  - sel=1 in cycles t+1 .. t+N, where N = max(hold_len,1)
  - GAP and done in t+N+1
  - IDLE in t+N+2
- Back-to-back minimum: the next request is accepted in t+N+2, so at most one hold per N+2 cycles.
- abort sampled in HOLD cycle u gives sel=0 and done=1 in u+1.
- All outputs are registered; no combinational path from any input to any output.
- rst asserted mid-hold: sel drops to 0 asynchronously, shadow_data clears, and any in-flight done is suppressed.

## Configuration
- PENDING_REQ_EN:
  - Defined: a one-entry pending flag plus a pending hold_len register.
    - freeze_req while in HOLD or GAP sets the flag and overwrites the pending length with the latest request.
    - On reaching IDLE with the flag set: capture and enter HOLD at the next edge as if freeze_req were present, then clear the flag. This is one cycle after GAP; IDLE still lasts one cycle.
    - abort does not clear the flag.
    - Reset clears the flag.
  - Undefined: requests outside IDLE are silently dropped; no pending storage is synthesized.

## Structure
- Shared package bus_hold_pkg holds:
  - state enum (IDLE, HOLD, GAP)
  - default WIDTH and CNT_W constants
  - snap_cnt width constant (8)
- One sub-module, hold_down_counter: loadable CNT_W down-counter with load, dec and is_one outputs. Everything else stays in bus_hold_ctrl.

## Test plan
- Basic hold: reset; live_data=8'hA5; freeze_req with hold_len=3 -> shadow_data=8'hA5, sel=1 for 3 cycles, done one cycle later, snap_cnt=1. Changing live_data to 8'h3C during the hold leaves shadow_data at 8'hA5.
- Zero length: hold_len=0 -> sel high for exactly 1 cycle, done in the following cycle.
- Abort: hold_len=10, abort in the 2nd HOLD cycle -> sel=0 and done=1 the next cycle, IDLE after; freeze_req together with abort in IDLE -> no capture, snap_cnt unchanged.
- Request during hold: freeze_req at the 2nd HOLD cycle.
  - PENDING_REQ_EN undefined: ignored, snap_cnt +1 only.
  - PENDING_REQ_EN defined: a second hold starts in the cycle after IDLE, snap_cnt +2.
- Wrap and reset: 256 holds -> snap_cnt back to 0. rst pulsed mid-hold -> sel, shadow_data and snap_cnt all 0 immediately, no done pulse.
